// File: rtl/summation_window_ctrl.sv
// Window counter sequencer and result qualifier for the boxcar summation datapath.
// Optional SUMMATION_WIN_AVG_EN: result is the window mean (sum >>> W) instead of the raw sum.
//
// state | meaning
// IDLE  | counter parked at 0, waiting for start
// SYNC  | counter running, first (partial) window being flushed
// ACQ   | counter running, every wrap schedules a result capture
// DONE  | single-shot complete, waiting for last result to drain
module summation_window_ctrl #(
  parameter int CNT_BITS  = 16,
  parameter int SUM_BITS  = 32,
  parameter int NWIN_BITS = 8,
  parameter int CAP_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 single,
  input  logic [4:0]           win_log2,
  input  logic [NWIN_BITS-1:0] n_win,
  output logic [CNT_BITS-1:0]  cnt_out,
  input  logic [SUM_BITS-1:0]  sum_in,
  output logic [SUM_BITS-1:0]  res_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    ACQ  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_BITS-1:0]    pos_q, pos_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;
  logic [4:0]             w_q, w_d;
  logic [NWIN_BITS-1:0]   nwin_q, nwin_d;
  logic [NWIN_BITS-1:0]   wcnt_q, wcnt_d;
  logic                   single_q, single_d;
  logic [CAP_LAT-1:0]     cap_sr_q, cap_sr_d;
  logic [SUM_BITS-1:0]    res_data_q, res_data_d;
  logic                   res_valid_q, res_valid_d;
  logic                   overrun_q, overrun_d;

  logic [CNT_BITS-1:0]    ones;
  logic [CNT_BITS-1:0]    mask;
  logic [4:0]             shift_amt;
  logic [4:0]             w_clamped;
  logic [NWIN_BITS-1:0]   n_clamped;
  logic                   running;
  logic                   wrap;
  logic                   capture;
  logic [SUM_BITS-1:0]    cap_value;

  // Window length is 2^W; the position is left-justified so the summation sees its MSB toggle.
  always_comb begin
    ones      = '1;
    shift_amt = 5'(CNT_BITS) - w_q;
    mask      = ones >> shift_amt;
    running   = (state_q == SYNC) || (state_q == ACQ);
    wrap      = running && (pos_q == mask);
    capture   = (state_q == ACQ) && cap_sr_q[CAP_LAT-1] && !stop;
  end

  always_comb begin
    if (win_log2 == 5'd0) begin
      w_clamped = 5'd1;
    end else if (win_log2 > 5'(CNT_BITS)) begin
      w_clamped = 5'(CNT_BITS);
    end else begin
      w_clamped = win_log2;
    end
    if (n_win == '0) begin
      n_clamped = NWIN_BITS'(1);
    end else begin
      n_clamped = n_win;
    end
  end

`ifdef SUMMATION_WIN_AVG_EN
  always_comb begin
    cap_value = SUM_BITS'($signed(sum_in) >>> w_q);
  end
`else
  always_comb begin
    cap_value = sum_in;
  end
`endif

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    w_d         = w_q;
    nwin_d      = nwin_q;
    wcnt_d      = wcnt_q;
    single_d    = single_q;
    cap_sr_d    = cap_sr_q << 1;
    cap_sr_d[0] = (state_q == ACQ) && wrap;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    overrun_d   = overrun_q;

    case (state_q)
      IDLE: begin
        pos_d    = '0;
        cap_sr_d = '0;
        if (start && !stop) begin
          w_d       = w_clamped;
          nwin_d    = n_clamped;
          single_d  = single;
          wcnt_d    = '0;
          overrun_d = 1'b0;
          state_d   = SYNC;
        end
      end
      SYNC: begin
        pos_d = (pos_q + 1'b1) & mask;
        if (wrap) begin
          state_d = ACQ;
        end
      end
      ACQ: begin
        pos_d = (pos_q + 1'b1) & mask;
        if (capture) begin
          wcnt_d = wcnt_q + 1'b1;
          if (single_q && (wcnt_d == nwin_q)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        pos_d    = '0;
        cap_sr_d = '0;
        if (!res_valid_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort drops any capture still in the pipeline but leaves the held result alone.
    if (stop && (state_q != IDLE)) begin
      state_d  = IDLE;
      pos_d    = '0;
      cap_sr_d = '0;
    end

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
    if (capture) begin
      res_valid_d = 1'b1;
      res_data_d  = cap_value;
      if (res_valid_q && !res_ready) begin
        overrun_d = 1'b1;
      end
    end

    cnt_d = pos_d << shift_amt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      cnt_q       <= '0;
      w_q         <= 5'd1;
      nwin_q      <= NWIN_BITS'(1);
      wcnt_q      <= '0;
      single_q    <= 1'b0;
      cap_sr_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      nwin_q      <= nwin_d;
      wcnt_q      <= wcnt_d;
      single_q    <= single_d;
      cap_sr_q    <= cap_sr_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cnt_out   = cnt_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_summation_window_ctrl.sv
// Directed + randomized bench for summation_window_ctrl with a window-arithmetic reference model.
module tb_summation_window_ctrl;
  localparam int CB = 16;
  localparam int SB = 32;
  localparam int NB = 8;
  localparam int CL = 2;
`ifdef SUMMATION_WIN_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start, stop, single;
  logic [4:0]    win_log2;
  logic [NB-1:0] n_win;
  logic [CB-1:0] cnt_out;
  logic [SB-1:0] sum_in;
  logic [SB-1:0] res_data;
  logic          res_valid, res_ready, busy, overrun;

  always #5 clk = ~clk;

  summation_window_ctrl #(.CNT_BITS(CB), .SUM_BITS(SB), .NWIN_BITS(NB), .CAP_LAT(CL)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .single(single),
    .win_log2(win_log2), .n_win(n_win), .cnt_out(cnt_out), .sum_in(sum_in),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;

  // Environment: either a behavioural summation block (sum_mode) or random sum_in per cycle.
  int     edge_cnt = 0;
  bit     sum_mode = 1'b0;
  int     in_data = 0;
  longint acc = 0;
  bit     prev_msb = 1'b0;

  // Reference model state: windows counted from the start edge.
  bit            m_run = 1'b0;
  bit            m_chk_valid = 1'b0;
  bit            m_chk_cnt = 1'b0;
  int            m_W = 1, m_P = 2, m_lim = 0, m_caps = 0, m_last_cap = 0;
  logic [SB-1:0] exp_q[$];

  function automatic logic [SB-1:0] expect_res(logic [SB-1:0] raw, int w);
    longint v, d, q;
    v = longint'($signed(raw));
    d = longint'(1) << w;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    return AVG_EN ? SB'(q) : raw;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic          pre_msb;
    logic [SB-1:0] pre_sum;
    logic [CB-1:0] exp_cnt;
    logic [SB-1:0] exp_data;
    bit            cap;
    pre_msb = cnt_out[CB-1];
    pre_sum = sum_in;
    @(posedge clk);
    #1;
    edge_cnt++;
    if (sum_mode) begin
      if (prev_msb && !pre_msb) begin
        sum_in = SB'(acc);
        acc = in_data;
      end else begin
        acc = acc + in_data;
      end
    end else begin
      sum_in = $urandom;
    end
    prev_msb = pre_msb;
    if (m_run) begin
      cap = (edge_cnt >= 2*m_P + CL) && (((edge_cnt - CL) % m_P) == 0) &&
            ((m_lim == 0) || (m_caps < m_lim));
      if (cap) begin
        m_caps++;
        m_last_cap = edge_cnt;
        exp_q.push_back(expect_res(pre_sum, m_W));
      end
      if (m_chk_valid) begin
        check("res_valid", 64'(res_valid), 64'(cap));
        if (cap) begin
          exp_data = exp_q.pop_front();
          check("res_data", 64'(res_data), 64'(exp_data));
        end
      end
      if (m_chk_cnt) begin
        exp_cnt = CB'(edge_cnt % m_P) << (CB - m_W);
        check("cnt_out", 64'(cnt_out), 64'(exp_cnt));
      end
    end
  endtask

  task automatic do_start(input int wl, input int nw, input bit sg, input bit cv, input bit cc);
    int weff;
    weff = (wl == 0) ? 1 : ((wl > CB) ? CB : wl);
    m_run = 1'b0;
    win_log2 = 5'(wl);
    n_win = NB'(nw);
    single = sg;
    start = 1'b1;
    tick();
    start = 1'b0;
    edge_cnt = 0;
    m_W = weff;
    m_P = 1 << weff;
    m_lim = sg ? ((nw == 0) ? 1 : nw) : 0;
    m_caps = 0;
    exp_q.delete();
    m_chk_valid = cv;
    m_chk_cnt = cc;
    m_run = 1'b1;
  endtask

  task automatic do_stop();
    m_run = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic run_single(input int w, input int n);
    int nn, c_edge;
    nn = (n == 0) ? 1 : n;
    c_edge = (nn + 1) * (1 << w) + CL;
    res_ready = 1'b1;
    do_start(w, n, 1'b1, 1'b1, 1'b0);
    while (edge_cnt < c_edge + 1) tick();
    check("single_busy_hold", 64'(busy), 64'd1);
    tick();
    check("single_busy_fall", 64'(busy), 64'd0);
    check("single_overrun", 64'(overrun), 64'd0);
    check("single_cnt_idle", 64'(cnt_out), 64'd0);
    repeat (3) tick();
    m_run = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0; stop = 1'b0; single = 1'b0;
    win_log2 = 5'd0; n_win = '0; sum_in = '0; res_ready = 1'b1;
    #1;
    check("rst_cnt_out", 64'(cnt_out), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    repeat (2) tick();
    #2 rst = 1'b1;
    repeat (2) tick();
    check("idle_busy", 64'(busy), 64'd0);

    // start and stop together in IDLE: stop wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 64'(busy), 64'd0);

    // free-run W=4 with the summation block fed constant 3
    sum_mode = 1'b1; in_data = 3; acc = 0;
    do_start(4, 0, 1'b0, 1'b1, 1'b1);
    check("freerun_busy", 64'(busy), 64'd1);
    repeat (70) tick();
    check("freerun_sum48", 64'(res_data), 64'(expect_res(SB'(in_data * 16), 4)));
    do_stop();
    check("freerun_stop_busy", 64'(busy), 64'd0);
    check("freerun_stop_cnt", 64'(cnt_out), 64'd0);

    // single-shot: directed W=3,n=3 then randomized shapes with random sums
    sum_mode = 1'b0;
    run_single(3, 3);
    for (int i = 0; i < 3; i++) begin
      run_single(int'($urandom_range(2, 5)), int'($urandom_range(0, 4)));
    end

    // backpressure through two captures, W=2
    res_ready = 1'b0;
    do_start(2, 0, 1'b0, 1'b0, 1'b1);
    while (edge_cnt < 10) tick();
    check("bp_valid1", 64'(res_valid), 64'd1);
    check("bp_data1", 64'(res_data), 64'(exp_q[0]));
    check("bp_ovr_clear", 64'(overrun), 64'd0);
    while (edge_cnt < 14) tick();
    check("bp_data2", 64'(res_data), 64'(exp_q[1]));
    check("bp_overrun", 64'(overrun), 64'd1);
    do_stop();
    check("bp_valid_held", 64'(res_valid), 64'd1);
    check("bp_data_held", 64'(res_data), 64'(exp_q[1]));
    res_ready = 1'b1;
    tick();
    check("bp_transfer", 64'(res_valid), 64'd0);
    check("bp_ovr_sticky", 64'(overrun), 64'd1);
    do_start(2, 1, 1'b1, 1'b0, 1'b0);
    check("bp_ovr_start_clr", 64'(overrun), 64'd0);
    do_stop();

    // stop one edge before the first scheduled capture, W=3
    do_start(3, 0, 1'b0, 1'b1, 1'b1);
    while (edge_cnt < 2*8 + CL - 2) tick();
    do_stop();
    check("stop_busy", 64'(busy), 64'd0);
    check("stop_cnt", 64'(cnt_out), 64'd0);
    check("stop_valid", 64'(res_valid), 64'd0);
    repeat (3) begin
      tick();
      check("stop_no_capture", 64'(res_valid), 64'd0);
    end

    // win_log2 clamping: 0 -> 1, 20 -> 16
    do_start(0, 0, 1'b0, 1'b0, 1'b1);
    repeat (10) tick();
    do_stop();
    do_start(20, 0, 1'b0, 1'b0, 1'b1);
    repeat (40) tick();
    check("clamp16_cnt", 64'(cnt_out), 64'd40);
    do_stop();

    // negative constant input, W=4
    sum_mode = 1'b1; in_data = -5; acc = 0;
    do_start(4, 0, 1'b0, 1'b1, 1'b1);
    while (edge_cnt < 2*16 + CL) tick();
    check("neg_valid", 64'(res_valid), 64'd1);
    check("neg_sum", 64'(res_data), 64'(expect_res(SB'(-80), 4)));

    // asynchronous reset in the middle of acquisition
    repeat (10) tick();
    m_run = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_cnt", 64'(cnt_out), 64'd0);
    check("arst_valid", 64'(res_valid), 64'd0);
    check("arst_data", 64'(res_data), 64'd0);
    check("arst_overrun", 64'(overrun), 64'd0);
    repeat (2) tick();
    #2 rst = 1'b1;
    repeat (5) tick();
    check("arst_idle_busy", 64'(busy), 64'd0);
    check("arst_idle_valid", 64'(res_valid), 64'd0);
    check("arst_idle_cnt", 64'(cnt_out), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
